// File: rtl/voting_machine.sv
// Four-candidate voting block: qualifies button holds into single votes, keeps
// saturating per-candidate tallies and drives a registered 8-bit LED bank.
module voting_machine #(
    parameter int HOLD_CYCLES  = 8,
    parameter int FLASH_CYCLES = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic [7:0] led
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(FLASH_CYCLES + 1);
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]    HOLD_FULL  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0]    HOLD_ONE   = HW'(1);
    localparam logic [TW-1:0]    FLASH_LOAD = TW'(FLASH_CYCLES);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    function automatic logic more_than_one(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

    logic [3:0]             btn_s;
    logic                   multi_s;
    logic [3:0][HW-1:0]     hold_r, hold_s;
    logic [3:0]             latch_r, latch_s;
    logic [3:0]             pulse_r, pulse_s;
    logic [3:0][CNT_W-1:0]  count_r, count_s;
    logic [TW-1:0]          timer_r, timer_s;
    logic [7:0]             led_r, led_s;

    assign btn_s   = {button4, button3, button2, button1};
    assign multi_s = more_than_one(btn_s);
    assign led     = led_r;

    // Press qualification: a lone hold of HOLD_CYCLES gives one pulse, the latch
    // suppresses repeats until the button is released.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hold_s[i]  = hold_r[i];
            latch_s[i] = latch_r[i];
            pulse_s[i] = 1'b0;
            if (!btn_s[i]) begin
                hold_s[i]  = {HW{1'b0}};
                latch_s[i] = 1'b0;
            end else if (mode || multi_s) begin
                hold_s[i] = {HW{1'b0}};
            end else if (!latch_r[i]) begin
                if (hold_r[i] == HOLD_LAST) begin
                    hold_s[i]  = HOLD_FULL;
                    latch_s[i] = 1'b1;
                    pulse_s[i] = 1'b1;
                end else begin
                    hold_s[i] = hold_r[i] + HOLD_ONE;
                end
            end else begin
                hold_s[i] = hold_r[i];
            end
        end
    end

    // Saturating tallies, advanced one cycle after the vote pulse.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            count_s[i] = count_r[i];
            if (!mode && pulse_r[i] && (count_r[i] != CNT_MAX)) begin
                count_s[i] = count_r[i] + CNT_ONE;
            end else begin
                count_s[i] = count_r[i];
            end
        end
    end

    // Flash timer: reloaded by an accepted vote, held at zero in result mode.
    always_comb begin
        timer_s = {TW{1'b0}};
        if (mode) begin
            timer_s = {TW{1'b0}};
        end else if (pulse_r != 4'b0000) begin
            timer_s = FLASH_LOAD;
        end else if (timer_r != {TW{1'b0}}) begin
            timer_s = timer_r - TIMER_ONE;
        end else begin
            timer_s = {TW{1'b0}};
        end
    end

    // LED source: fixed-priority count select in result mode, flash otherwise.
    always_comb begin
        led_s = 8'h00;
        if (mode) begin
            if (btn_s[0]) begin
                led_s = count_r[0];
            end else if (btn_s[1]) begin
                led_s = count_r[1];
            end else if (btn_s[2]) begin
                led_s = count_r[2];
            end else if (btn_s[3]) begin
                led_s = count_r[3];
            end else begin
                led_s = 8'h00;
            end
        end else if (timer_s != {TW{1'b0}}) begin
            led_s = 8'hFF;
        end else begin
            led_s = 8'h00;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r  <= '0;
            latch_r <= 4'b0000;
            pulse_r <= 4'b0000;
            count_r <= '0;
            timer_r <= {TW{1'b0}};
            led_r   <= 8'h00;
        end else begin
            hold_r  <= hold_s;
            latch_r <= latch_s;
            pulse_r <= pulse_s;
            count_r <= count_s;
            timer_r <= timer_s;
            led_r   <= led_s;
        end
    end

endmodule

// File: tb/tb_voting_machine.sv
// Directed bench for voting_machine: a cycle-stamped tally model checks led every
// cycle, and hand-computed literals pin the tallies and flash window.
module tb_voting_machine;

    localparam int H = 8;
    localparam int F = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       button1 = 1'b0;
    logic       button2 = 1'b0;
    logic       button3 = 1'b0;
    logic       button4 = 1'b0;
    logic [7:0] led;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    voting_machine dut (
        .clk(clk), .rst(rst), .mode(mode),
        .button1(button1), .button2(button2), .button3(button3), .button4(button4),
        .led(led)
    );

    // Reference model: run lengths of lone presses, timestamped vote application
    // and a flash window expressed as an absolute last cycle.
    int         cyc = 0;
    int         run[4];
    bit         voted[4];
    int         counts[4];
    int         pend_btn = -1;
    int         pend_time = 0;
    int         flash_end = -1;
    bit         model_valid = 1'b0;
    logic [7:0] led_exp = 8'h00;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: led=%h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_step();
        logic [3:0] b;
        int nb;
        int pre[4];
        b  = {button4, button3, button2, button1};
        nb = $countones(b);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                run[i] = 0; voted[i] = 1'b0; counts[i] = 0;
            end
            pend_btn = -1; flash_end = -1; led_exp = 8'h00; model_valid = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) pre[i] = counts[i];
            if (pend_btn >= 0 && pend_time == cyc) begin
                if (!mode) begin
                    if (counts[pend_btn] < 255) counts[pend_btn]++;
                    flash_end = cyc + F - 1;
                end
                pend_btn = -1;
            end
            if (mode) begin
                flash_end = -1;
                if (b[0])      led_exp = 8'(pre[0]);
                else if (b[1]) led_exp = 8'(pre[1]);
                else if (b[2]) led_exp = 8'(pre[2]);
                else if (b[3]) led_exp = 8'(pre[3]);
                else           led_exp = 8'h00;
            end else begin
                led_exp = (cyc <= flash_end) ? 8'hFF : 8'h00;
            end
            for (int i = 0; i < 4; i++) begin
                if (!b[i]) begin
                    run[i] = 0; voted[i] = 1'b0;
                end else if (mode || nb > 1) begin
                    run[i] = 0;
                end else if (!voted[i]) begin
                    run[i]++;
                    if (run[i] == H) begin
                        voted[i] = 1'b1; pend_btn = i; pend_time = cyc + 1;
                    end
                end
            end
        end
        cyc++;
    endtask

    // Per-cycle compare against the model, just after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            if (model_valid) chk("led_cycle", led, led_exp);
        end
    end

    task automatic set_btn(input logic [3:0] m);
        button1 = m[0]; button2 = m[1]; button3 = m[2]; button4 = m[3];
    endtask

    task automatic press(input logic [3:0] m, input int len, input int gap);
        @(negedge clk); set_btn(m);
        repeat (len) @(negedge clk);
        set_btn(4'b0000);
        repeat (gap) @(negedge clk);
    endtask

    task automatic view(input logic [3:0] m, input logic [7:0] exp, input string name);
        @(negedge clk); set_btn(m);
        repeat (2) @(negedge clk);
        chk(name, led, exp);
        set_btn(4'b0000);
    endtask

    int nff;
    int first_ff;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_led", led, 8'h00);
        mode = 1'b1;
        view(4'b0001, 8'd0, "reset_c1");
        view(4'b0010, 8'd0, "reset_c2");
        view(4'b0100, 8'd0, "reset_c3");
        view(4'b1000, 8'd0, "reset_c4");

        mode = 1'b0;
        press(4'b0001, 10, 3); press(4'b0010, 10, 3); press(4'b0001, 10, 3);
        press(4'b0100, 10, 3); press(4'b0010, 10, 3); press(4'b0010, 10, 3);
        press(4'b0001, 10, 3);
        mode = 1'b1;
        view(4'b0001, 8'd3, "tally_c1");
        view(4'b0010, 8'd3, "tally_c2");
        view(4'b0100, 8'd1, "tally_c3");
        view(4'b1000, 8'd0, "tally_c4");

        mode = 1'b0;
        press(4'b0001, 7, 3);
        mode = 1'b1;
        view(4'b0001, 8'd3, "short_press");

        mode = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); set_btn(4'b0001);
        nff = 0; first_ff = -1;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (led === 8'hFF) begin
                nff++;
                if (first_ff < 0) first_ff = j;
            end
        end
        set_btn(4'b0000);
        chk_int("flash_len", nff, 10);
        chk_int("flash_start", first_ff, 9);
        mode = 1'b1;
        view(4'b0001, 8'd4, "long_hold");

        mode = 1'b0;
        press(4'b0011, 20, 3);
        mode = 1'b1;
        view(4'b0011, 8'd4, "priority");
        view(4'b0010, 8'd3, "simul_c2");

        press(4'b0100, 20, 3);
        view(4'b0100, 8'd1, "mode1_c3");

        mode = 1'b0;
        @(negedge clk); set_btn(4'b0010);
        repeat (9) @(negedge clk);
        chk("flash_on", led, 8'hFF);
        mode = 1'b1; set_btn(4'b0000);
        @(negedge clk); mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("flash_cleared", led, 8'h00);
        mode = 1'b1;
        view(4'b0010, 8'd4, "flash_vote_c2");

        mode = 1'b0;
        repeat (260) press(4'b1000, 9, 1);
        mode = 1'b1;
        view(4'b1000, 8'd255, "saturate_c4");

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("reset2_led", led, 8'h00);
        view(4'b1000, 8'd0, "reset2_c4");
        view(4'b0001, 8'd0, "reset2_c1");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
